// File: rtl/ccnet_pkg.sv
// Shared CCNET constants, device status codes and the receive FSM state type.
// Imported by the frame receiver and the CRC helper.
package ccnet_pkg;

   localparam logic [7:0]  SYNC     = 8'h02;
   localparam logic [7:0]  ADDR_BV  = 8'h03;
   localparam logic [15:0] CRC_POLY = 16'h8408;
   localparam logic [7:0]  LNG_MIN  = 8'd6;

   // Validator status / command codes
   localparam logic [7:0] POWER_UP     = 8'h10;
   localparam logic [7:0] INITIALIZE   = 8'h13;
   localparam logic [7:0] IDLING       = 8'h14;
   localparam logic [7:0] ACCEPTING    = 8'h15;
   localparam logic [7:0] STACKING     = 8'h17;
   localparam logic [7:0] DISABLED     = 8'h19;
   localparam logic [7:0] REJECTING    = 8'h1C;
   localparam logic [7:0] BILL_STACKED = 8'h81;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADR,
      ST_LNG,
      ST_CMD,
      ST_DATA,
      ST_CRC_LO,
      ST_CRC_HI
   } rx_state_t;

endpackage

// File: rtl/ccnet_frame_rx_if.sv
// Byte input and parsed-frame outputs of the CCNET receiver.
// master = byte source / frame consumer side, slave = the parser.
interface ccnet_frame_rx_if #(
   parameter int MAX_DATA = 8
);
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  frame_valid;
   logic [7:0]            frame_cmd;
   logic [7:0]            frame_len;
   logic [8*MAX_DATA-1:0] frame_data;
   logic                  bill_stacked;
   logic [7:0]            bill_type;
   logic                  crc_err;
   logic                  len_err;
   logic                  timeout_err;

   modport master (
      output rx_data, rx_ready,
      input  frame_valid, frame_cmd, frame_len, frame_data,
      input  bill_stacked, bill_type, crc_err, len_err, timeout_err
   );

   modport slave (
      input  rx_data, rx_ready,
      output frame_valid, frame_cmd, frame_len, frame_data,
      output bill_stacked, bill_type, crc_err, len_err, timeout_err
   );
endinterface

// File: rtl/ccnet_crc16.sv
// Combinational one-byte update of the CCNET CRC16 (reflected 0x8408, LSB first).
// Kept standalone so the TX framer can reuse it.
module ccnet_crc16
   import ccnet_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [15:0] crc_out
);

   logic [15:0] crc_work;

   always_comb begin
      crc_work = crc_in ^ {8'h00, data_in};
      for (int i = 0; i < 8; i++) begin
         if (crc_work[0]) begin
            crc_work = (crc_work >> 1) ^ CRC_POLY;
         end else begin
            crc_work = crc_work >> 1;
         end
      end
      crc_out = crc_work;
   end

endmodule

// File: rtl/ccnet_frame_rx.sv
// CCNET receive framer: assembles validator bytes into frames, checks ADR/LNG/CRC,
// publishes good frames and decodes bill-stacked events.
module ccnet_frame_rx
   import ccnet_pkg::*;
#(
   parameter int         CLK_FREQ       = 10000000,
   parameter int         TIMEOUT_CYCLES = CLK_FREQ / 100,
   parameter int         MAX_DATA       = 8,
   parameter logic [7:0] BV_ADDR        = ADDR_BV
) (
   input logic             CLK_10MHZ,
   input logic             RST,
   ccnet_frame_rx_if.slave rx_if
);

   localparam int              TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]      LNG_MAX = 8'(int'(LNG_MIN) + MAX_DATA);
   localparam int              DW      = 8 * MAX_DATA;

   rx_state_t       state_q, state_d;
   logic            rx_ready_q;
   logic [15:0]     crc_q, crc_d;
   logic [7:0]      crc_lo_q, crc_lo_d;
   logic [7:0]      cmd_q, cmd_d;
   logic [7:0]      cnt_q, cnt_d;
   logic [7:0]      idx_q, idx_d;
   logic [DW-1:0]   data_buf_q, data_buf_d;
   logic [TO_W-1:0] to_q, to_d;

   logic            frame_valid_q, frame_valid_d;
   logic [7:0]      frame_cmd_q, frame_cmd_d;
   logic [7:0]      frame_len_q, frame_len_d;
   logic [DW-1:0]   frame_data_q, frame_data_d;
   logic            bill_stacked_q, bill_stacked_d;
   logic [7:0]      bill_type_q, bill_type_d;
   logic            crc_err_q, crc_err_d;
   logic            len_err_q, len_err_d;
   logic            timeout_err_q, timeout_err_d;

   logic            accept;
   logic            adr_resync;
   logic [15:0]     crc_base;
   logic [15:0]     crc_next;

   assign accept     = rx_if.rx_ready && !rx_ready_q;
   assign adr_resync = (rx_if.rx_data == SYNC) && (rx_if.rx_data != BV_ADDR);

   // A SYNC byte (from IDLE, or a resync while waiting for ADR) restarts the CRC from zero
   assign crc_base = ((state_q == ST_IDLE) || ((state_q == ST_ADR) && adr_resync)) ? 16'h0000 : crc_q;

   ccnet_crc16 u_crc16 (
      .crc_in  (crc_base),
      .data_in (rx_if.rx_data),
      .crc_out (crc_next)
   );

   always_comb begin
      state_d        = state_q;
      crc_d          = crc_q;
      crc_lo_d       = crc_lo_q;
      cmd_d          = cmd_q;
      cnt_d          = cnt_q;
      idx_d          = idx_q;
      data_buf_d     = data_buf_q;
      to_d           = to_q;
      frame_valid_d  = 1'b0;
      frame_cmd_d    = frame_cmd_q;
      frame_len_d    = frame_len_q;
      frame_data_d   = frame_data_q;
      bill_stacked_d = 1'b0;
      bill_type_d    = bill_type_q;
      crc_err_d      = 1'b0;
      len_err_d      = 1'b0;
      timeout_err_d  = 1'b0;

      // An accepted byte always beats timeout expiry in the same cycle
      if (state_q == ST_IDLE || accept) begin
         to_d = '0;
      end else if (to_q == TO_LAST) begin
         timeout_err_d = 1'b1;
         to_d          = '0;
         state_d       = ST_IDLE;
      end else begin
         to_d = to_q + 1'b1;
      end

      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (rx_if.rx_data == SYNC) begin
                  crc_d   = crc_next;
                  state_d = ST_ADR;
               end
            end
            ST_ADR: begin
               if (rx_if.rx_data == BV_ADDR) begin
                  crc_d   = crc_next;
                  state_d = ST_LNG;
               end else if (adr_resync) begin
                  crc_d   = crc_next;
                  state_d = ST_ADR;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_LNG: begin
               if (rx_if.rx_data >= LNG_MIN && rx_if.rx_data <= LNG_MAX) begin
                  crc_d      = crc_next;
                  cnt_d      = rx_if.rx_data - LNG_MIN;
                  data_buf_d = '0;
                  state_d    = ST_CMD;
               end else begin
                  len_err_d = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_CMD: begin
               crc_d   = crc_next;
               cmd_d   = rx_if.rx_data;
               idx_d   = 8'd0;
               state_d = (cnt_q == 8'd0) ? ST_CRC_LO : ST_DATA;
            end
            ST_DATA: begin
               crc_d = crc_next;
               for (int i = 0; i < MAX_DATA; i++) begin
                  if (idx_q == 8'(i)) begin
                     data_buf_d[8*i +: 8] = rx_if.rx_data;
                  end
               end
               idx_d = idx_q + 8'd1;
               if (idx_q == cnt_q - 8'd1) begin
                  state_d = ST_CRC_LO;
               end
            end
            ST_CRC_LO: begin
               crc_lo_d = rx_if.rx_data;
               state_d  = ST_CRC_HI;
            end
            ST_CRC_HI: begin
               state_d = ST_IDLE;
               if ({rx_if.rx_data, crc_lo_q} == crc_q) begin
                  frame_valid_d = 1'b1;
                  frame_cmd_d   = cmd_q;
                  frame_len_d   = cnt_q;
                  frame_data_d  = data_buf_q;
                  if (cmd_q == BILL_STACKED && cnt_q != 8'd0) begin
                     bill_stacked_d = 1'b1;
                     bill_type_d    = data_buf_q[7:0];
                  end
               end else begin
                  crc_err_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK_10MHZ or posedge RST) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         rx_ready_q     <= 1'b0;
         crc_q          <= '0;
         crc_lo_q       <= '0;
         cmd_q          <= '0;
         cnt_q          <= '0;
         idx_q          <= '0;
         data_buf_q     <= '0;
         to_q           <= '0;
         frame_valid_q  <= 1'b0;
         frame_cmd_q    <= '0;
         frame_len_q    <= '0;
         frame_data_q   <= '0;
         bill_stacked_q <= 1'b0;
         bill_type_q    <= '0;
         crc_err_q      <= 1'b0;
         len_err_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         rx_ready_q     <= rx_if.rx_ready;
         crc_q          <= crc_d;
         crc_lo_q       <= crc_lo_d;
         cmd_q          <= cmd_d;
         cnt_q          <= cnt_d;
         idx_q          <= idx_d;
         data_buf_q     <= data_buf_d;
         to_q           <= to_d;
         frame_valid_q  <= frame_valid_d;
         frame_cmd_q    <= frame_cmd_d;
         frame_len_q    <= frame_len_d;
         frame_data_q   <= frame_data_d;
         bill_stacked_q <= bill_stacked_d;
         bill_type_q    <= bill_type_d;
         crc_err_q      <= crc_err_d;
         len_err_q      <= len_err_d;
         timeout_err_q  <= timeout_err_d;
      end
   end

   assign rx_if.frame_valid  = frame_valid_q;
   assign rx_if.frame_cmd    = frame_cmd_q;
   assign rx_if.frame_len    = frame_len_q;
   assign rx_if.frame_data   = frame_data_q;
   assign rx_if.bill_stacked = bill_stacked_q;
   assign rx_if.bill_type    = bill_type_q;
   assign rx_if.crc_err      = crc_err_q;
   assign rx_if.len_err      = len_err_q;
   assign rx_if.timeout_err  = timeout_err_q;

endmodule
